obstacle_ctrl: RTL and testbench
================================

OBSTACLE_CTRL -- requirements
Module: obstacle_ctrl

Interface
REQ-001 The block SHALL have parameter BIRD_X_L, default 300: left edge of the bird box in pixels.
REQ-002 The block SHALL have parameter BIRD_X_R, default 340: right edge of the bird box in pixels.
REQ-003 The block SHALL have parameter BIRD_H, default 20: bird box height in pixels.
REQ-004 The block SHALL have parameter CONFIRM, default 2: consecutive collision cycles required before Stop.
REQ-005 The block SHALL have parameter HOLD, default 16: DEAD cycles during which button presses are ignored.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port Btn, input, 1 bit: raw asynchronous player button, active-high.
REQ-009 The block SHALL have port Bird_Y, input, 10 bits: bird top edge.
REQ-010 The block SHALL have ports X_Edge_L and X_Edge_R, input, 10 bits each: left and right edges of the pipe currently in scope.
REQ-011 The block SHALL have ports Gap_Top and Gap_Bot, input, 10 bits each: gap bounds of the in-scope pipe.
REQ-012 The block SHALL have ports Q_Initial, Q_Count and Q_Stop, input, 1 bit each: one-hot state of the pipe mover.
REQ-013 The block SHALL have port Score, input, 4 bits: score from the pipe mover.
REQ-014 The block SHALL have ports Start, Stop and Ack, output, 1 bit each: handshake to the pipe mover.
REQ-015 The block SHALL have port Game_Over, output, 1 bit: high while in DEAD.
REQ-016 The block SHALL have port High_Score, output, 4 bits: best score since reset.
REQ-017 The block SHALL have ports Q_Idle, Q_Run, Q_StopReq and Q_Dead, output, 1 bit each: one-hot state.

Function
REQ-018 The block SHALL pass Btn through a 2-flop synchronizer and a registered previous-value flop; btn_edge = sync & ~prev.
- Btn first sampled high at edge k gives btn_edge high between edges k+1 and k+2.
REQ-019 The FSM SHALL have four one-hot states: IDLE, RUN, STOPREQ, DEAD; unreachable encodings SHALL return to IDLE.
REQ-020 In IDLE, btn_edge with Q_Initial=1 SHALL register Start=1 for exactly one cycle and move to RUN.
- Latency: Start rises at edge k+2.
- btn_edge with Q_Initial=0 SHALL be ignored.
REQ-021 The collision condition SHALL be xhit & (Bird_Y < Gap_Top | Bird_Y+BIRD_H > Gap_Bot) | (Bird_Y+BIRD_H > 479).
- xhit = (X_Edge_L < BIRD_X_R) & (X_Edge_R > BIRD_X_L).
- All sums SHALL be computed at 11 bits with no wrap-around.
REQ-022 In RUN, a saturating 2-bit hit counter SHALL increment on each cycle the collision condition is true and clear to 0 on each cycle it is false.
REQ-023 When the condition is true and the counter equals CONFIRM-1, the FSM SHALL register Stop=1 and enter STOPREQ.
REQ-024 In STOPREQ, Stop SHALL remain 1 until Q_Stop is sampled 1; Stop SHALL then clear on that same edge and the FSM SHALL enter DEAD.
REQ-025 The DEAD entry edge SHALL load High_Score with Score if Score > High_Score; otherwise High_Score SHALL hold.
REQ-026 In DEAD, a hold counter SHALL count from 0 to HOLD and then saturate; btn_edge SHALL be ignored until the counter reaches HOLD.
REQ-027 After the hold expires, btn_edge with Q_Stop=1 SHALL register Ack=1 for exactly one cycle, clear the hold counter, and move to IDLE.
REQ-028 Start, Ack and Stop SHALL never be high simultaneously; at most one handshake output SHALL be high in any cycle.
REQ-029 A collision and btn_edge arriving in the same RUN cycle SHALL cause the button to be ignored.
REQ-030 A Q_Stop in RUN without a prior Stop SHALL be ignored.
REQ-031 A Btn held high SHALL produce only one btn_edge.

Reset
REQ-032 When reset=0, the block SHALL asynchronously force state IDLE, Start=Stop=Ack=0, Game_Over=0, High_Score=0, and clear the hit counter, hold counter and synchronizer flops.
REQ-033 Reset asserted mid-game SHALL abandon any handshake; no pulse SHALL be emitted on reset release.
REQ-034 After reset release, the first Start SHALL require a new 0->1 Btn transition.

Verification
REQ-035 Bench SHALL cover start: Q_Initial=1, Btn rises before edge 10 -> Start=1 for one cycle at edge 12, Q_Run=1.
REQ-036 Bench SHALL cover glitch rejection: in RUN, Bird_Y=50, Gap_Top=100, xhit true for one cycle only -> Stop stays 0.
REQ-037 Bench SHALL cover a pipe hit: X_Edge_L=310, X_Edge_R=381, Bird_Y=50, Gap_Top=100 for 2 cycles -> Stop=1; Q_Stop rises 1 cycle later -> Stop=0, Game_Over=1, Score=5 gives High_Score=5.
REQ-038 Bench SHALL cover a floor hit: Bird_Y=465 with no pipe overlap -> Stop after CONFIRM cycles; Bird_Y=459 -> no Stop.
REQ-039 Bench SHALL cover the hold window: Btn edge 5 cycles into DEAD -> no Ack; edge after 16 cycles -> one-cycle Ack, Q_Idle=1; a later game with Score=3 leaves High_Score=5.
REQ-040 Bench SHALL cover reset mid-operation: reset=0 during STOPREQ -> all outputs 0 immediately, High_Score=0, Q_Idle=1.

Source files
------------

// File: rtl/obstacle_ctrl.sv
// Game-flow controller: debounces the player button, confirms collisions
// and runs the start/stop/ack handshake with the pipe mover.
module obstacle_ctrl #(
  parameter int BIRD_X_L = 300,
  parameter int BIRD_X_R = 340,
  parameter int BIRD_H   = 20,
  parameter int CONFIRM  = 2,
  parameter int HOLD     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Btn,
  input  logic [9:0] Bird_Y,
  input  logic [9:0] X_Edge_L,
  input  logic [9:0] X_Edge_R,
  input  logic [9:0] Gap_Top,
  input  logic [9:0] Gap_Bot,
  input  logic       Q_Initial,
  input  logic       Q_Count,
  input  logic       Q_Stop,
  input  logic [3:0] Score,
  output logic       Start,
  output logic       Stop,
  output logic       Ack,
  output logic       Game_Over,
  output logic [3:0] High_Score,
  output logic       Q_Idle,
  output logic       Q_Run,
  output logic       Q_StopReq,
  output logic       Q_Dead
);

  localparam logic [3:0] S_IDLE    = 4'b0001;
  localparam logic [3:0] S_RUN     = 4'b0010;
  localparam logic [3:0] S_STOPREQ = 4'b0100;
  localparam logic [3:0] S_DEAD    = 4'b1000;

  localparam int HW = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_V  = HW'(HOLD);
  localparam logic [1:0]    CONF_M1 = 2'(CONFIRM - 1);
  localparam logic [9:0]    BXL     = 10'(BIRD_X_L);
  localparam logic [9:0]    BXR     = 10'(BIRD_X_R);

  logic          sync1, sync2, prev;
  logic          armed;
  logic [1:0]    fill;
  logic          btn_edge;
  logic [3:0]    st;
  logic [1:0]    hit_cnt;
  logic [HW-1:0] hold_cnt;
  logic [10:0]   bird_bot;
  logic          xhit, gap_miss, floor_hit, hit;
  logic          unused_q_count;

  assign unused_q_count = Q_Count;

  // armed needs a genuinely sampled low after reset, so a button
  // held through reset release cannot fire a start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync1 <= Btn;
      sync2 <= sync1;
      prev  <= sync2;
      fill  <= {fill[0], 1'b1};
      if (fill[1] && !sync2)
        armed <= 1'b1;
    end
  end

  assign btn_edge = sync2 & ~prev & armed;

  assign bird_bot  = {1'b0, Bird_Y} + 11'(BIRD_H);
  assign xhit      = (X_Edge_L < BXR) & (X_Edge_R > BXL);
  assign gap_miss  = (Bird_Y < Gap_Top) |
                     (bird_bot > {1'b0, Gap_Bot});
  assign floor_hit = bird_bot > 11'd479;
  assign hit       = (xhit & gap_miss) | floor_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= S_IDLE;
      Start      <= 1'b0;
      Stop       <= 1'b0;
      Ack        <= 1'b0;
      hit_cnt    <= 2'd0;
      hold_cnt   <= '0;
      High_Score <= 4'd0;
    end else begin
      Start <= 1'b0;
      Ack   <= 1'b0;
      case (st)
        S_IDLE: begin
          Stop     <= 1'b0;
          hit_cnt  <= 2'd0;
          hold_cnt <= '0;
          if (btn_edge && Q_Initial) begin
            Start <= 1'b1;
            st    <= S_RUN;
          end
        end
        S_RUN: begin
          if (hit) begin
            if (hit_cnt == CONF_M1) begin
              Stop <= 1'b1;
              st   <= S_STOPREQ;
            end
            if (hit_cnt != 2'b11)
              hit_cnt <= hit_cnt + 2'd1;
          end else begin
            hit_cnt <= 2'd0;
          end
        end
        S_STOPREQ: begin
          if (Q_Stop) begin
            Stop     <= 1'b0;
            hold_cnt <= '0;
            st       <= S_DEAD;
            if (Score > High_Score)
              High_Score <= Score;
          end
        end
        S_DEAD: begin
          if (hold_cnt != HOLD_V) begin
            hold_cnt <= hold_cnt + HW'(1);
          end else if (btn_edge && Q_Stop) begin
            Ack      <= 1'b1;
            hold_cnt <= '0;
            st       <= S_IDLE;
          end
        end
        default: begin
          Stop <= 1'b0;
          st   <= S_IDLE;
        end
      endcase
    end
  end

  assign Q_Idle    = st[0];
  assign Q_Run     = st[1];
  assign Q_StopReq = st[2];
  assign Q_Dead    = st[3];
  assign Game_Over = st[3];

endmodule

// File: tb/tb_obstacle_ctrl.sv
// Directed bench for obstacle_ctrl: start, collision confirm, floor,
// hold window, high score and mid-game reset.
module tb_obstacle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       Btn;
  logic [9:0] Bird_Y, X_Edge_L, X_Edge_R, Gap_Top, Gap_Bot;
  logic       Q_Initial, Q_Count, Q_Stop;
  logic [3:0] Score;
  logic       Start, Stop, Ack, Game_Over;
  logic [3:0] High_Score;
  logic       Q_Idle, Q_Run, Q_StopReq, Q_Dead;

  int errors = 0;
  int checks = 0;

  obstacle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Btn        (Btn),
    .Bird_Y     (Bird_Y),
    .X_Edge_L   (X_Edge_L),
    .X_Edge_R   (X_Edge_R),
    .Gap_Top    (Gap_Top),
    .Gap_Bot    (Gap_Bot),
    .Q_Initial  (Q_Initial),
    .Q_Count    (Q_Count),
    .Q_Stop     (Q_Stop),
    .Score      (Score),
    .Start      (Start),
    .Stop       (Stop),
    .Ack        (Ack),
    .Game_Over  (Game_Over),
    .High_Score (High_Score),
    .Q_Idle     (Q_Idle),
    .Q_Run      (Q_Run),
    .Q_StopReq  (Q_StopReq),
    .Q_Dead     (Q_Dead)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      assert ($onehot0({Start, Stop, Ack})) else begin
        errors++;
        $error("FAIL excl: observed=%b expected=onehot0",
               {Start, Stop, Ack});
      end
    end
  end

  initial begin
    reset = 1'b0; Btn = 1'b0;
    Bird_Y = 10'd50; X_Edge_L = 10'd0; X_Edge_R = 10'd0;
    Gap_Top = 10'd100; Gap_Bot = 10'd200;
    Q_Initial = 1'b0; Q_Count = 1'b0; Q_Stop = 1'b0;
    Score = 4'd0;

    tick(2);
    chk("rst_hs", {4'd0, High_Score}, 8'd0);
    chk("rst_out", {4'd0, Start, Stop, Ack, Game_Over}, 8'd0);
    chk("rst_st", {4'd0, Q_Dead, Q_StopReq, Q_Run, Q_Idle}, 8'h1);
    reset = 1'b1;
    Q_Initial = 1'b1;

    // Btn first sampled at edge 10, Start expected at edge 12
    tick(9);
    Btn = 1'b1;
    tick(1); chk("start_e10", {7'd0, Start}, 8'd0);
    tick(1); chk("start_e11", {7'd0, Start}, 8'd0);
    tick(1); chk("start_e12", {7'd0, Start}, 8'd1);
    chk("start_run", {7'd0, Q_Run}, 8'd1);
    tick(1); chk("start_e13", {7'd0, Start}, 8'd0);
    tick(3); chk("btn_held", {6'd0, Start, Q_Run}, 8'd1);
    Btn = 1'b0; Q_Initial = 1'b0;

    // single-cycle pipe overlap must not stop
    tick(1);
    X_Edge_L = 10'd310; X_Edge_R = 10'd381;
    tick(1); chk("glitch_1", {7'd0, Stop}, 8'd0);
    X_Edge_L = 10'd0; X_Edge_R = 10'd0;
    tick(1); chk("glitch_2", {7'd0, Stop}, 8'd0);
    tick(2); chk("glitch_run", {6'd0, Stop, Q_Run}, 8'd1);

    // confirmed pipe hit
    X_Edge_L = 10'd310; X_Edge_R = 10'd381;
    tick(1); chk("pipe_c1", {7'd0, Stop}, 8'd0);
    tick(1); chk("pipe_c2", {7'd0, Stop}, 8'd1);
    chk("pipe_sreq", {7'd0, Q_StopReq}, 8'd1);
    X_Edge_L = 10'd0; X_Edge_R = 10'd0; Score = 4'd5;
    tick(1); chk("stop_hold", {7'd0, Stop}, 8'd1);
    Q_Stop = 1'b1;
    tick(1); chk("dead_stop", {7'd0, Stop}, 8'd0);
    chk("dead_go", {6'd0, Game_Over, Q_Dead}, 8'h3);
    chk("hs_5", {4'd0, High_Score}, 8'd5);

    // press inside hold window is ignored
    tick(4);
    Btn = 1'b1;
    tick(1); chk("hold_a1", {7'd0, Ack}, 8'd0);
    tick(1); chk("hold_a2", {7'd0, Ack}, 8'd0);
    tick(1); chk("hold_a3", {7'd0, Ack}, 8'd0);
    tick(1); chk("hold_dead", {6'd0, Ack, Q_Dead}, 8'd1);
    Btn = 1'b0;
    tick(15);
    Btn = 1'b1;
    tick(2); chk("ack_early", {7'd0, Ack}, 8'd0);
    tick(1); chk("ack_pulse", {7'd0, Ack}, 8'd1);
    chk("ack_idle", {6'd0, Game_Over, Q_Idle}, 8'd1);
    tick(1); chk("ack_end", {7'd0, Ack}, 8'd0);
    Btn = 1'b0; Q_Stop = 1'b0;

    // second game: stray Q_Stop, floor margin, floor hit, low score
    tick(3);
    Q_Initial = 1'b1; Btn = 1'b1;
    tick(3); chk("g2_start", {6'd0, Start, Q_Run}, 8'h3);
    tick(1);
    Btn = 1'b0; Q_Initial = 1'b0;
    Q_Stop = 1'b1;
    tick(2); chk("stray_qs", {5'd0, Stop, Game_Over, Q_Run}, 8'd1);
    Q_Stop = 1'b0;
    Bird_Y = 10'd459;
    tick(3); chk("floor_459", {6'd0, Stop, Q_Run}, 8'd1);
    Bird_Y = 10'd465; Btn = 1'b1;
    tick(1); chk("floor_c1", {7'd0, Stop}, 8'd0);
    tick(1); chk("floor_c2", {6'd0, Start, Stop}, 8'd1);
    Btn = 1'b0; Bird_Y = 10'd50; Score = 4'd3; Q_Stop = 1'b1;
    tick(1); chk("g2_dead", {7'd0, Q_Dead}, 8'd1);
    chk("hs_keep", {4'd0, High_Score}, 8'd5);
    tick(18);
    Btn = 1'b1;
    tick(3); chk("g2_ack", {6'd0, Ack, Q_Idle}, 8'h3);
    Btn = 1'b0; Q_Stop = 1'b0;
    tick(3);

    // third game, reset while in STOPREQ
    Q_Initial = 1'b1; Btn = 1'b1;
    tick(3); chk("g3_start", {7'd0, Start}, 8'd1);
    tick(1);
    Q_Initial = 1'b0;
    X_Edge_L = 10'd310; X_Edge_R = 10'd381;
    tick(2); chk("g3_sreq", {6'd0, Stop, Q_StopReq}, 8'h3);
    #2 reset = 1'b0;
    #1;
    chk("mid_out", {4'd0, Start, Stop, Ack, Game_Over}, 8'd0);
    chk("mid_hs", {4'd0, High_Score}, 8'd0);
    chk("mid_st", {4'd0, Q_Dead, Q_StopReq, Q_Run, Q_Idle}, 8'h1);
    X_Edge_L = 10'd0; X_Edge_R = 10'd0;
    Q_Initial = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1); chk("rel_1", {6'd0, Start, Q_Idle}, 8'd1);
    tick(5); chk("rel_held", {6'd0, Start, Q_Idle}, 8'd1);
    Btn = 1'b0;
    tick(3);
    Btn = 1'b1;
    tick(2); chk("rel_early", {7'd0, Start}, 8'd0);
    tick(1); chk("rel_start", {6'd0, Start, Q_Run}, 8'h3);
    Btn = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
